// File: rtl/riscv_pkg.sv
// Shared opcode, funct, ALU-control and sequencer-state definitions for the
// multi-cycle RV64 control unit.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LDSD   = 3'b011;
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_BEQ    = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction/data memory handshake bundle between the control unit (master)
// and the memory side (slave).
interface multicycle_control_unit_if;

    logic [31:0] instr_in;
    logic        imem_ready;
    logic        imem_req;
    logic        dmem_ready;
    logic        dmem_req;
    logic        dmem_we;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  instr_in, imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output instr_in, imem_ready, dmem_ready
    );

endinterface

// File: rtl/alu_control_decoder.sv
// Combinational decode of opcode/funct3/funct7 into the ALU operation and a
// legality flag for the supported LD/SD/ADD/SUB/AND/OR/BEQ subset.
module alu_control_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_control_o,
    output logic       legal_o
);

    // Opcode and funct decode; anything unmatched is flagged illegal.
    always_comb begin
        alu_control_o = ALU_ADD;
        legal_o       = 1'b0;
        case (opcode_i)
            OP_LOAD, OP_STORE: begin
                alu_control_o = ALU_ADD;
                legal_o       = (funct3_i == F3_LDSD);
            end
            OP_BRANCH: begin
                alu_control_o = ALU_SUB;
                legal_o       = (funct3_i == F3_BEQ);
            end
            OP_RTYPE: begin
                case ({funct7_i, funct3_i})
                    {F7_BASE, F3_ADDSUB}: begin
                        alu_control_o = ALU_ADD;
                        legal_o       = 1'b1;
                    end
                    {F7_SUB, F3_ADDSUB}: begin
                        alu_control_o = ALU_SUB;
                        legal_o       = 1'b1;
                    end
                    {F7_BASE, F3_AND}: begin
                        alu_control_o = ALU_AND;
                        legal_o       = 1'b1;
                    end
                    {F7_BASE, F3_OR}: begin
                        alu_control_o = ALU_OR;
                        legal_o       = 1'b1;
                    end
                    default: begin
                        alu_control_o = ALU_ADD;
                        legal_o       = 1'b0;
                    end
                endcase
            end
            default: begin
                alu_control_o = ALU_ADD;
                legal_o       = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the RV64 datapath: owns PC and IR, steps each
// instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK with a memory watchdog.
module multicycle_control_unit
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          TIMEOUT  = 16
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_unit_if.master  bus,
    input  logic                       alu_zero,
    input  logic [63:0]                imm,
    output logic [63:0]                instructionAddress,
    output logic [31:0]                ir,
    output logic                       reg_write,
    output logic                       alu_src,
    output logic                       mem_to_reg,
    output logic [3:0]                 alu_control,
    output logic [2:0]                 state,
    output logic                       illegal,
    output logic                       bus_error
);

    localparam logic [2:0] S_FETCH     = ST_FETCH;
    localparam logic [2:0] S_DECODE    = ST_DECODE;
    localparam logic [2:0] S_EXECUTE   = ST_EXECUTE;
    localparam logic [2:0] S_MEM       = ST_MEM;
    localparam logic [2:0] S_WRITEBACK = ST_WRITEBACK;
    localparam logic [2:0] S_HALT      = ST_HALT;

    localparam int unsigned     CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    logic             cnt_inc_s;
    logic             tmo_s;
    logic             is_ld_s;
    logic             is_sd_s;
    logic             is_mem_s;
    logic             is_beq_s;
    logic [3:0]       dec_alu_s;
    logic             dec_legal_s;

    alu_control_decoder u_alu_dec (
        .opcode_i      (ir_q[6:0]),
        .funct3_i      (ir_q[14:12]),
        .funct7_i      (ir_q[31:25]),
        .alu_control_o (dec_alu_s),
        .legal_o       (dec_legal_s)
    );

    assign is_ld_s  = (ir_q[6:0] == OP_LOAD);
    assign is_sd_s  = (ir_q[6:0] == OP_STORE);
    assign is_mem_s = is_ld_s | is_sd_s;
    assign is_beq_s = (ir_q[6:0] == OP_BRANCH);
    assign tmo_s    = (cnt_q == TMO_LAST);

    // Sequencer next-state, PC/IR update and sticky error flags.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        cnt_inc_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    ir_d    = bus.instr_in;
                    state_d = S_DECODE;
                end else if (tmo_s) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_legal_s) begin
                    state_d = S_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXECUTE: begin
                if (is_beq_s) begin
                    pc_d    = alu_zero ? (pc_q + imm) : (pc_q + 64'd4);
                    state_d = S_FETCH;
                end else if (is_mem_s) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                // Ready on the final watchdog cycle still completes the access.
                if (bus.dmem_ready) begin
                    if (is_sd_s) begin
                        pc_d    = pc_q + 64'd4;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (tmo_s) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            S_WRITEBACK: begin
                pc_d    = pc_q + 64'd4;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_inc_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Moore control decode; fetch request is also masked while reset is held.
    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        reg_write    = 1'b0;
        alu_src      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_control  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                bus.imem_req = rst_n;
            end
            S_EXECUTE: begin
                alu_src     = is_mem_s;
                alu_control = dec_alu_s;
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = is_sd_s;
                alu_src      = is_mem_s;
                alu_control  = dec_alu_s;
            end
            S_WRITEBACK: begin
                reg_write   = 1'b1;
                mem_to_reg  = is_ld_s;
                alu_src     = is_mem_s;
                alu_control = dec_alu_s;
            end
            default: begin
                bus.imem_req = 1'b0;
            end
        endcase
    end

    assign instructionAddress = pc_q;
    assign ir                 = ir_q;
    assign state              = state_q;
    assign illegal            = illegal_q;
    assign bus_error          = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: an instruction-level reference
// model is compared every cycle, plus literal checks at key points.
module tb_multicycle_control_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_zero;
    logic [63:0] imm;
    logic [63:0] instructionAddress;
    logic [31:0] ir;
    logic        reg_write, alu_src, mem_to_reg, illegal, bus_error;
    logic [3:0]  alu_control;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(.RESET_PC(64'h0), .TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus                (bus),
        .alu_zero           (alu_zero),
        .imm                (imm),
        .instructionAddress (instructionAddress),
        .ir                 (ir),
        .reg_write          (reg_write),
        .alu_src            (alu_src),
        .mem_to_reg         (mem_to_reg),
        .alu_control        (alu_control),
        .state              (state),
        .illegal            (illegal),
        .bus_error          (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction patterns as mask/value pairs: class 1=LD 2=SD 3=R 4=BEQ, 0=illegal.
    logic [31:0] pat_mask [7] = '{32'h0000707F, 32'h0000707F, 32'hFE00707F, 32'hFE00707F,
                                  32'hFE00707F, 32'hFE00707F, 32'h0000707F};
    logic [31:0] pat_val  [7] = '{32'h00003003, 32'h00003023, 32'h00000033, 32'h40000033,
                                  32'h00007033, 32'h00006033, 32'h00000063};
    int          pat_cls  [7] = '{1, 2, 3, 3, 3, 3, 4};
    logic [3:0]  pat_alu  [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0110};

    // Phase sequence per class (0 F,1 D,2 E,3 M,4 W); an instruction retires after its last step.
    int seq_tab [5][5] = '{'{0, 1, 5, 5, 5}, '{0, 1, 2, 3, 4}, '{0, 1, 2, 3, 5},
                           '{0, 1, 2, 4, 5}, '{0, 1, 2, 5, 5}};
    int seq_len [5]    = '{2, 5, 4, 4, 3};

    function automatic int cls_of(input logic [31:0] w);
        for (int i = 0; i < 7; i++)
            if ((w & pat_mask[i]) == pat_val[i]) return pat_cls[i];
        return 0;
    endfunction

    function automatic logic [3:0] alu_of(input logic [31:0] w);
        for (int i = 0; i < 7; i++)
            if ((w & pat_mask[i]) == pat_val[i]) return pat_alu[i];
        return 4'b0010;
    endfunction

    int          m_step, m_wait, m_phase;
    logic [63:0] m_pc;
    logic [31:0] m_ir;
    logic        m_ill, m_be, m_halt, m_go;

    assign m_phase = m_halt ? 5 : seq_tab[cls_of(m_ir)][m_step];
    assign m_go    = (m_phase == 0 && bus.imem_ready) || (m_phase == 3 && bus.dmem_ready) ||
                     (m_phase == 1 && cls_of(m_ir) != 0) || m_phase == 2 || m_phase == 4;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_step <= 0; m_wait <= 0; m_pc <= 64'h0; m_ir <= 32'h0;
            m_ill <= 1'b0; m_be <= 1'b0; m_halt <= 1'b0;
        end else if (m_halt) begin
            m_halt <= 1'b1;
        end else if (m_go) begin
            m_wait <= 0;
            if (m_phase == 0) m_ir <= bus.instr_in;
            if (m_step + 1 >= seq_len[cls_of(m_ir)]) begin
                m_step <= 0;
                m_pc   <= (cls_of(m_ir) == 4 && alu_zero) ? m_pc + imm : m_pc + 64'd4;
            end else begin
                m_step <= m_step + 1;
            end
        end else if (m_phase == 1) begin
            m_ill <= 1'b1; m_halt <= 1'b1;
        end else if (m_wait == TIMEOUT - 1) begin
            m_be <= 1'b1; m_halt <= 1'b1;
        end else begin
            m_wait <= m_wait + 1;
        end
    end

    always @(negedge clk) begin
        chk("state", state, m_phase);
        chk("pc", instructionAddress, m_pc);
        chk("ir", ir, m_ir);
        chk("imem_req", bus.imem_req, rst_n && m_phase == 0);
        chk("dmem_req", bus.dmem_req, m_phase == 3);
        chk("dmem_we", bus.dmem_we, m_phase == 3 && cls_of(m_ir) == 2);
        chk("reg_write", reg_write, m_phase == 4);
        chk("illegal", illegal, m_ill);
        chk("bus_error", bus_error, m_be);
        chk("rw_we_excl", reg_write && bus.dmem_we, 1'b0);
        chk("req_excl", bus.imem_req && bus.dmem_req, 1'b0);
        if (m_phase == 2 || m_phase == 3) begin
            chk("alu_src", alu_src, cls_of(m_ir) == 1 || cls_of(m_ir) == 2);
            chk("alu_control", alu_control, alu_of(m_ir));
        end
        if (m_phase == 0 || m_phase == 5) chk("alu_control_idle", alu_control, 4'b0010);
        if (m_phase == 4) chk("mem_to_reg", mem_to_reg, cls_of(m_ir) == 1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.instr_in = 32'h0;
        imm = 64'h0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Fetch one instruction and run it to FETCH or HALT; dmem_ready comes after dwait MEM cycles.
    task automatic run_instr(input logic [31:0] w, input logic [63:0] iv, input logic z,
                             input int dwait, output int rw_cnt, output int we_cnt,
                             output logic [3:0] ex_alu);
        int  mc;
        bit  done;
        mc = 0; done = 1'b0; rw_cnt = 0; we_cnt = 0; ex_alu = 4'hF;
        bus.instr_in = w; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
        imm = iv; alu_zero = z;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (m_phase == 0 || m_phase == 5) begin
                done = 1'b1;
            end else begin
                if (reg_write) rw_cnt++;
                if (bus.dmem_we) we_cnt++;
                if (state == 3'd2) ex_alu = alu_control;
                bus.dmem_ready = (m_phase == 3) && (mc == dwait);
                if (m_phase == 3) mc++;
                @(posedge clk); #1;
            end
        end
        bus.dmem_ready = 1'b0;
        if (!done) chk("instr_bound", 1'b0, 1'b1);
    endtask

    initial begin
        int         rw, we;
        logic [3:0] ea;

        do_reset();
        chk("rst_state", state, 3'd0);
        chk("rst_pc", instructionAddress, 64'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_alu", alu_control, 4'b0010);
        chk("rst_dmem_req", bus.dmem_req, 1'b0);

        run_instr(32'h00003083, 64'h0, 1'b0, 0, rw, we, ea);
        chk("ld_pc", instructionAddress, 64'd4);
        chk("ld_rw", rw, 1);
        chk("ld_alu", ea, 4'b0010);

        run_instr(32'h00103423, 64'd8, 1'b0, 3, rw, we, ea);
        chk("sd_we_cycles", we, 4);
        chk("sd_rw", rw, 0);
        chk("sd_pc", instructionAddress, 64'd8);

        run_instr(32'h002081B3, 64'h0, 1'b0, 0, rw, we, ea);
        chk("add_alu", ea, 4'b0010);
        chk("add_rw", rw, 1);
        chk("add_pc", instructionAddress, 64'd12);
        run_instr(32'h402081B3, 64'h0, 1'b0, 0, rw, we, ea);
        chk("sub_alu", ea, 4'b0110);
        chk("sub_pc", instructionAddress, 64'd16);

        run_instr(32'h00000463, 64'd8, 1'b1, 0, rw, we, ea);
        chk("beq_taken_pc", instructionAddress, 64'd24);
        chk("beq_alu", ea, 4'b0110);
        run_instr(32'h00000463, 64'd8, 1'b0, 0, rw, we, ea);
        chk("beq_not_taken_pc", instructionAddress, 64'd28);

        run_instr(32'h00000463, 64'hFFFF_FFFF_FFFF_FFE0, 1'b1, 0, rw, we, ea);
        chk("beq_neg_pc", instructionAddress, 64'hFFFF_FFFF_FFFF_FFFC);
        run_instr(32'h0020E1B3, 64'h0, 1'b0, 0, rw, we, ea);
        chk("or_alu", ea, 4'b0001);
        chk("pc_wrap", instructionAddress, 64'h0);
        run_instr(32'h0020F1B3, 64'h0, 1'b0, 0, rw, we, ea);
        chk("and_alu", ea, 4'b0000);
        chk("and_pc", instructionAddress, 64'd4);

        run_instr(32'hFFFF_FFFF, 64'h0, 1'b0, 0, rw, we, ea);
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("ill_state", state, 3'd5);
        chk("ill_flag", illegal, 1'b1);
        chk("ill_imem_req", bus.imem_req, 1'b0);
        rst_n = 1'b0; #1;
        chk("ill_rst_pc", instructionAddress, 64'h0);
        chk("ill_rst_flag", illegal, 1'b0);
        do_reset();

        run_instr(32'h022081B3, 64'h0, 1'b0, 0, rw, we, ea);
        chk("rtype_bad_funct7", illegal, 1'b1);
        do_reset();

        repeat (15) @(posedge clk);
        #1 chk("pre_tmo_state", state, 3'd0);
        bus.instr_in = 32'h002081B3; bus.imem_ready = 1'b1;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        chk("ready_wins_state", state, 3'd1);
        chk("ready_wins_be", bus_error, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("ready_wins_pc", instructionAddress, 64'd4);
        do_reset();

        repeat (15) @(posedge clk);
        #1 chk("fetch_15_state", state, 3'd0);
        @(posedge clk); #1;
        chk("fetch_tmo_state", state, 3'd5);
        chk("fetch_tmo_be", bus_error, 1'b1);
        do_reset();

        run_instr(32'h00103423, 64'd8, 1'b0, 99, rw, we, ea);
        chk("mem_tmo_we_cycles", we, TIMEOUT);
        chk("mem_tmo_be", bus_error, 1'b1);
        do_reset();

        bus.instr_in = 32'h00003083; bus.imem_ready = 1'b1;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("mid_mem_req", bus.dmem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_dmem_req", bus.dmem_req, 1'b0);
        chk("async_state", state, 3'd0);
        chk("async_reg_write", reg_write, 1'b0);
        do_reset();
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
